// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage.
// Provides:
//   FLAG_*   bit positions inside an NZCV nibble
//   nzcv_t   packed 4-bit flag word, bit3=N bit2=Z bit1=C bit0=V
//   entry_t  one buffered result: sum, its derived flags and the setf tag
// RESULT_W is the datapath width used by entry_t; it must match the stage's N.
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int RESULT_W = 8;

  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    nzcv_t               nzcv;
    logic                setf;
  } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the adder, the result stage and its consumer.
// Ports (from the stage's point of view, modport slave):
//   in_valid, in_result, in_v, in_c, in_setf  producer side inputs
//   in_ready                                   stage can accept
//   out_valid, out_result, out_nzcv            head entry to consumer
//   out_ready                                  consumer accepts head
//   nzcv_q                                     committed architectural flags
// Modport master is the environment driving the stage.
interface alu_result_stage_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic         in_v;
  logic         in_c;
  logic         in_setf;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_nzcv;
  logic [3:0]   nzcv_q;

  modport slave (
    input  in_valid, in_result, in_v, in_c, in_setf, out_ready,
    output in_ready, out_valid, out_result, out_nzcv, nzcv_q
  );

  modport master (
    output in_valid, in_result, in_v, in_c, in_setf, out_ready,
    input  in_ready, out_valid, out_result, out_nzcv, nzcv_q
  );
endinterface

// File: rtl/alu_result_stage_flag_derive.sv
// Combinational flag derivation for an adder result.
// Ports:
//   result  adder sum
//   c, v    carry-out and overflow from the adder, passed through
//   nzcv    derived flag word (N = sign bit, Z = result is zero)
module flag_derive
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] result,
  input  logic         c,
  input  logic         v,
  output nzcv_t        nzcv
);

  always_comb begin
    nzcv         = '0;
    nzcv[FLAG_N] = result[N-1];
    nzcv[FLAG_Z] = (result == '0);
    nzcv[FLAG_C] = c;
    nzcv[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ripple adder.
// Captures sum + derived NZCV into a two-entry skid buffer (head plus one
// overflow register) and commits flags to nzcv_q when a setf entry pops.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alu_result_stage_if.slave (valid/ready in, valid/ready out, nzcv_q)
// in_ready is a register decoded from the next count, so the adder never
// sees a combinational path from out_ready.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = RESULT_W,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus
);

  nzcv_t      in_nzcv;
  entry_t     in_entry;
  entry_t     head_q;
  entry_t     ovf_q;
  logic [1:0] count_q;
  logic [1:0] count_next;
  logic       in_ready_q;
  logic       out_valid_q;
  nzcv_t      nzcv_q;
  logic       push;
  logic       pop;

  flag_derive #(.N(N)) u_flag_derive (
    .result (bus.in_result),
    .c      (bus.in_c),
    .v      (bus.in_v),
    .nzcv   (in_nzcv)
  );

  assign in_entry = '{result: bus.in_result, nzcv: in_nzcv, setf: bus.in_setf};

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      nzcv_q      <= '0;
    end else begin
      count_q     <= count_next;
      in_ready_q  <= (count_next < 2'(DEPTH));
      out_valid_q <= (count_next != 2'd0);

      if (pop && head_q.setf)
        nzcv_q <= head_q.nzcv;

      // A pop to empty leaves head_q untouched so outputs hold their last value.
      if (pop) begin
        if (count_q == 2'd2)
          head_q <= ovf_q;
        else if (push)
          head_q <= in_entry;
      end else if (push) begin
        if (count_q == 2'd0)
          head_q <= in_entry;
        else
          ovf_q <= in_entry;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = head_q.result;
  assign bus.out_nzcv   = head_q.nzcv;
  assign bus.nzcv_q     = nzcv_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_result_stage_if #(.N(8)) bus ();

  alu_result_stage #(.N(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    logic       s;
  } m_entry_t;

  m_entry_t   mq[$];
  logic [3:0] m_nzcv = 4'b0000;

  function automatic logic [3:0] flags_of(logic [7:0] r, logic c, logic v);
    logic n, z;
    n = (r >= 8'h80);
    z = (r == 8'h00);
    return {n, z, c, v};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of at most two entries.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_nzcv = 4'b0000;
    end else begin
      bit do_push, do_pop;
      m_entry_t e;
      do_push = bus.in_valid && (mq.size() < 2);
      do_pop  = (mq.size() > 0) && bus.out_ready;
      if (do_pop) begin
        if (mq[0].s) m_nzcv = mq[0].f;
        void'(mq.pop_front());
      end
      if (do_push) begin
        e.r = bus.in_result;
        e.f = flags_of(bus.in_result, bus.in_c, bus.in_v);
        e.s = bus.in_setf;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("out_result", 32'(bus.out_result), 32'(mq[0].r));
        check("out_nzcv", 32'(bus.out_nzcv), 32'(mq[0].f));
      end
      check("nzcv_q", 32'(bus.nzcv_q), 32'(m_nzcv));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [7:0] r, logic c, logic ov, logic s, logic ordy);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_c      = c;
    bus.in_v      = ov;
    bus.in_setf   = s;
    bus.out_ready = ordy;
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst nzcv_q", 32'(bus.nzcv_q), 32'd0);
    check("rst out_result", 32'(bus.out_result), 32'd0);
    check("rst out_nzcv", 32'(bus.out_nzcv), 32'd0);

    // zero result with carry, flag-setting
    drive(1, 8'h00, 1, 0, 1, 1);
    cyc();
    drive(0, 8'h00, 0, 0, 0, 1);
    check("zero out_valid", 32'(bus.out_valid), 32'd1);
    check("zero out_nzcv", 32'(bus.out_nzcv), 32'b0110);
    cyc();
    check("zero nzcv_q", 32'(bus.nzcv_q), 32'b0110);
    check("zero empty", 32'(bus.out_valid), 32'd0);

    // 7F + 01 overflow
    drive(1, 8'h80, 0, 1, 1, 0);
    cyc();
    drive(0, 8'h00, 0, 0, 0, 0);
    check("ovf out_nzcv", 32'(bus.out_nzcv), 32'b1001);
    check("ovf nzcv_q held", 32'(bus.nzcv_q), 32'b0110);
    bus.out_ready = 1;
    cyc();
    check("ovf nzcv_q", 32'(bus.nzcv_q), 32'b1001);

    // back-pressure: A, B accepted, C refused
    drive(1, 8'h11, 0, 0, 0, 0);
    cyc();
    drive(1, 8'h22, 0, 0, 0, 0);
    cyc();
    check("bp in_ready", 32'(bus.in_ready), 32'd0);
    drive(1, 8'h33, 0, 0, 0, 0);
    cyc();
    drive(0, 8'h00, 0, 0, 0, 0);
    check("bp head A", 32'(bus.out_result), 32'h11);
    bus.out_ready = 1;
    cyc();
    check("bp head B", 32'(bus.out_result), 32'h22);
    check("bp B valid", 32'(bus.out_valid), 32'd1);
    cyc();
    check("bp drained", 32'(bus.out_valid), 32'd0);
    check("bp nzcv_q", 32'(bus.nzcv_q), 32'b1001);

    // push/pop together at count=1
    drive(1, 8'h04, 0, 0, 0, 0);
    cyc();
    drive(1, 8'h05, 0, 0, 0, 1);
    cyc();
    drive(0, 8'h00, 0, 0, 0, 1);
    check("pp valid", 32'(bus.out_valid), 32'd1);
    check("pp head", 32'(bus.out_result), 32'h05);
    check("pp in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    check("pp drained", 32'(bus.out_valid), 32'd0);

    // setf=0 negative result does not commit
    drive(1, 8'hFF, 0, 0, 0, 0);
    cyc();
    drive(0, 8'h00, 0, 0, 0, 0);
    check("nosetf out_nzcv", 32'(bus.out_nzcv), 32'b1000);
    bus.out_ready = 1;
    cyc();
    check("nosetf nzcv_q", 32'(bus.nzcv_q), 32'b1001);

    // directed stream with alternating back-pressure
    for (int i = 0; i < 16; i++) begin
      drive(1'(i % 3 != 2), 8'(i * 37), 1'(i[1]), 1'(i[2]), 1'(i[0]), 1'(i % 4 != 1));
      cyc();
    end
    drive(0, 8'h00, 0, 0, 0, 1);
    cyc();
    cyc();
    cyc();

    // reset with two entries buffered and nzcv_q = 0110
    drive(1, 8'h00, 1, 0, 1, 1);
    cyc();
    drive(0, 8'h00, 0, 0, 0, 1);
    cyc();
    check("prerst nzcv_q", 32'(bus.nzcv_q), 32'b0110);
    drive(1, 8'h41, 0, 0, 1, 0);
    cyc();
    drive(1, 8'h42, 0, 0, 1, 0);
    cyc();
    drive(0, 8'h00, 0, 0, 0, 0);
    check("prerst full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst nzcv_q", 32'(bus.nzcv_q), 32'd0);
    check("midrst out_result", 32'(bus.out_result), 32'd0);
    bus.out_ready = 1;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the N-bit ripple adder/flag unit. It captures the combinational sum and the V/C flags and derives N and Z.
- Buffers up to two results in a valid/ready skid buffer so the adder never sees a combinational ready path from the consumer.
- Keeps the architectural NZCV register, updated only when a flag-setting result is handed to the consumer.

Parameters:
- N, 8, datapath width; matches the adder width.
- DEPTH, 2, skid buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  adder result valid this cycle.
- in_ready  out  1  stage can accept; registered, equals buffer not full.
- in_result  in  N  adder sum C[N-1:0].
- in_v  in  1  adder overflow flag (flag[0]).
- in_c  in  1  adder carry-out flag (flag[1]).
- in_setf  in  1  this result updates NZCV when committed.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts head.
- out_result  out  N  head result.
- out_nzcv  out  4  head entry flags, bit3=N bit2=Z bit1=C bit0=V.
- nzcv_q  out  4  committed architectural flags, same bit order.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - count=0, out_valid=0, in_ready=1, nzcv_q=4'b0000.
  - out_result and out_nzcv = 0.
  - Storage contents don't care.
- Flag derivation, at capture time:
  - N = in_result[N-1].
  - Z = (in_result == 0).
  - C = in_c, V = in_v.
  - Stored per entry together with in_setf.
- Handshakes:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = (count < 2), registered from count. It depends only on state, never on out_ready.
  - out_valid = (count > 0).
- Latency: 1 cycle. A value pushed at edge k is visible on out_* after edge k; there is no bypass.
- Ordering: strict FIFO.
  - Head register plus one overflow register.
  - On pop with count=2, the overflow entry moves to head in the same edge.
- Count transitions per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop at count=1: new entry becomes head, count stays 1.
  - push and pop at count=2: impossible (in_ready=0).
  - push at count=0: entry goes to head.
- Full: count=2 forces in_ready=0. in_* are ignored while in_ready=0, even if in_valid=1.
- Empty: out_result and out_nzcv hold their last value (reset value 0 after reset). The consumer must not sample them with out_valid=0.
- NZCV commit:
  - On pop with the head setf=1, nzcv_q <= head flags at that edge.
  - setf=0 entries leave nzcv_q unchanged.
  - nzcv_q never changes on push.
- Stability: while out_valid=1 and out_ready=0, out_result and out_nzcv hold stable.
- Reset mid-operation: buffered entries are discarded and nzcv_q is cleared. Nothing from before reset is ever presented.
- Width rules: no arithmetic beyond the zero compare; results pass through unmodified.

Decomposition:
- Package alu_pkg:
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef nzcv_t (4-bit packed).
  - typedef entry_t {result, nzcv, setf}, parameterised by N through a generic width constant.
- One natural sub-module, flag_derive: combinational N/Z from result, plus C/V pass-through, producing nzcv_t.
- Buffer control stays in the top module.

Test Plan:
- Reset, then push in_result=8'h00, in_c=1, in_v=0, setf=1, out_ready=1:
  - next cycle out_valid=1, out_nzcv=4'b0110.
  - after the pop edge, nzcv_q=4'b0110.
- Overflow case, 8'h7F+8'h01 from the adder: in_result=8'h80, v=1, c=0, setf=1 -> out_nzcv=4'b1001.
- Back-pressure with out_ready=0, pushes A=8'h11, B=8'h22, then C=8'h33:
  - in_ready=0 after the second push.
  - C is not accepted.
  - Raising out_ready yields 8'h11 then 8'h22 in order.
- Simultaneous push/pop at count=1: push 8'h05 while 8'h04 pops -> count stays 1, head=8'h05, no bubble.
- setf=0 entry with in_result=8'hFF popped -> out_nzcv=4'b1000, nzcv_q unchanged from its prior value.
- Assert rst with two entries buffered and nzcv_q=4'b0110 -> next cycle out_valid=0, in_ready=1, nzcv_q=0.
